gate_test_seq: RTL



---
 rtl/gate_test_seq_pkg.sv | 19 +
 rtl/gate_test_seq_settle_timer.sv | 26 ++
 rtl/gate_test_seq.sv | 112 +++++++++++
 3 files changed

// File: rtl/gate_test_seq_pkg.sv
// Shared types and helpers for the NAND3/NOR3 gate self-test sequencer.
package gate_test_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [2:0] VEC_LAST  = 3'd7;
    localparam logic       MODE_NAND = 1'b0;
    localparam logic       MODE_NOR  = 1'b1;

    function automatic logic gate_expect(input logic mode, input logic [2:0] vec);
        return (mode == MODE_NOR) ? ~(|vec) : ~(&vec);
    endfunction

endpackage

// File: rtl/gate_test_seq_settle_timer.sv
// Settle counter: cleared by load, counts up while enabled, flags the last settle cycle.
module settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    logic [3:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + 4'd1;
        end
    end

    assign expired = (count == 4'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/gate_test_seq.sv
// Gate self-test sequencer: walks 8 input vectors, scores gate_y against NAND3/NOR3.
// Optional first-failure capture with `GATE_TEST_FAIL_CAPTURE_EN.
module gate_test_seq
    import gate_test_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode,
    input  logic       gate_y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count
`ifdef GATE_TEST_FAIL_CAPTURE_EN
    ,
    output logic [2:0] fail_vec,
    output logic       fail_valid
`endif
);

    state_t     state;
    logic [2:0] vec;
    logic       mode_q;
    logic       expired;
    logic       timer_load;
    logic       timer_en;
    logic       mismatch;
    logic [3:0] err_next;

    settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .en      (timer_en),
        .expired (expired)
    );

    // Case-inequality so an X/Z gate output is scored as a mismatch.
    always_comb begin
        timer_load = ((state == IDLE) && start) || (state == SAMPLE);
        timer_en   = (state == SETTLE);
        mismatch   = (gate_y !== gate_expect(mode_q, vec));
        err_next   = err_count + {3'b000, mismatch};
    end

    assign a = vec[2];
    assign b = vec[1];
    assign c = vec[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            vec        <= '0;
            mode_q     <= MODE_NAND;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
`ifdef GATE_TEST_FAIL_CAPTURE_EN
            fail_vec   <= '0;
            fail_valid <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        vec       <= '0;
                        mode_q    <= mode;
                        err_count <= '0;
                        pass      <= 1'b0;
`ifdef GATE_TEST_FAIL_CAPTURE_EN
                        fail_valid <= 1'b0;
`endif
                        busy      <= 1'b1;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (expired) state <= SAMPLE;
                end
                SAMPLE: begin
                    err_count <= err_next;
`ifdef GATE_TEST_FAIL_CAPTURE_EN
                    if (mismatch && !fail_valid) begin
                        fail_vec   <= vec;
                        fail_valid <= 1'b1;
                    end
`endif
                    if (vec == VEC_LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 4'd0);
                        state <= DONE;
                    end else begin
                        vec   <= vec + 3'd1;
                        state <= SETTLE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
